// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states, widths.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 30;

  // Access size encodings on MemDataType; 2'b11 is reserved and always illegal.
  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    FIN
  } state_e;

  // A request is legal when it is a single operation of a defined size and naturally aligned.
  function automatic logic req_legal(input logic rd, input logic wr, input logic [1:0] dtype,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = !(rd && wr);
    if (dtype == 2'b11) ok = 1'b0;
    if (dtype == DT_HALF && addr_lo[0]) ok = 1'b0;
    if (dtype == DT_WORD && addr_lo != 2'b00) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane extraction with sign extension, and sub-word store merge.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  dtype,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half and sign-extend it for loads.
  always_comb begin
    byte_sel  = rdata[{lane, 3'b000} +: 8];
    half_sel  = rdata[{lane[1], 4'b0000} +: 16];
    load_data = rdata;
    unique case (dtype)
      DT_BYTE: load_data = {{24{byte_sel[7]}}, byte_sel};
      DT_HALF: load_data = {{16{half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replace only the addressed lane of the fetched word; word stores bypass the merge.
  always_comb begin
    merged = rdata;
    unique case (dtype)
      DT_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      DT_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit bridging the pipeline to a word-wide memory with a req/ack handshake.
// Sub-word stores are done as read-modify-write of the containing word.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            MemDataType,
  input  logic [31:0]           Address,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  AccessError,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  state_e      state;
  logic [1:0]  dtype_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        req_any;
  logic        legal;

  lane_align u_lane_align (
    .dtype     (dtype_q),
    .lane      (lane_q),
    .rdata     (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Request decode; error and stall must respond in the same IDLE cycle as the request.
  always_comb begin
    req_any     = MemRead || MemWrite;
    legal       = req_any && req_legal(MemRead, MemWrite, MemDataType, Address[1:0]);
    AccessError = (state == IDLE) && req_any && !legal;
    Stall       = ((state == IDLE) && legal) || mem_req;
  end

  // Controller FSM with registered handshake, completion and captured-operand outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      Done      <= 1'b0;
      ReadData  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dtype_q   <= DT_BYTE;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (legal) begin
            mem_addr <= Address[31:2];
            lane_q   <= Address[1:0];
            dtype_q  <= MemDataType;
            wdata_q  <= WriteData;
            mem_req  <= 1'b1;
            if (MemRead) begin
              state  <= RD;
              mem_we <= 1'b0;
            end else if (MemDataType == DT_WORD) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= WriteData;
            end else begin
              state  <= RMW_RD;
              mem_we <= 1'b0;
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            ReadData <= load_data;
            mem_req  <= 1'b0;
            Done     <= 1'b1;
            state    <= FIN;
          end
        end
        RMW_RD: begin
          if (mem_ack) begin
            mem_wdata <= merged;
            mem_we    <= 1'b1;
            state     <= RMW_WR;
          end
        end
        WR, RMW_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            Done    <= 1'b1;
            state   <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-memory responder and a result scoreboard.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  MemDataType = 2'b00;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        AccessError;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd = '0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        wr;
    logic [29:0] waddr;
    logic [31:0] wdata;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 Clk = ~Clk;

  mem_access_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemDataType (MemDataType),
    .Address     (Address),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .Done        (Done),
    .AccessError (AccessError),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [1:0] dt, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] sh;
    if (dt == 2'b00) begin
      sh = word >> (8 * int'(addr[1:0]));
      return {{24{sh[7]}}, sh[7:0]};
    end else if (dt == 2'b01) begin
      sh = word >> (16 * int'(addr[1]));
      return {{16{sh[15]}}, sh[15:0]};
    end
    return word;
  endfunction

  function automatic logic [31:0] st_model(input logic [1:0] dt, input logic [31:0] addr,
                                           input logic [31:0] wd, input logic [31:0] word);
    logic [31:0] mask;
    int          sh;
    if (dt == 2'b10) return wd;
    sh   = (dt == 2'b00) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
    mask = ((dt == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (word & ~mask) | ((wd << sh) & mask);
  endfunction

  // Present a legal access at the current negedge, act as memory, and score it at Done.
  task automatic run_op(input string tag, input logic rd, input logic [1:0] dt,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] word, input int waits);
    exp_t e;
    exp_t got;
    int   cyc;
    int   stalls;
    int   wcnt;
    int   phases;
    logic seen_wr;
    logic [29:0] obs_waddr;
    logic [31:0] obs_wdata;
    phases = (!rd && dt != 2'b10) ? 2 : 1;
    e.tag  = tag;
    if (rd) exp_rd = ld_model(dt, addr, word);
    e.rd    = exp_rd;
    e.wr    = !rd;
    e.waddr = addr[31:2];
    e.wdata = rd ? 32'h0 : st_model(dt, addr, wd, word);
    e.lat   = (phases + 1) + phases * waits;
    sb_q.push_back(e);

    MemRead = rd; MemWrite = !rd; MemDataType = dt; Address = addr; WriteData = wd;
    mem_ack = 1'b0;
    #1;
    chk({tag, "_err_idle"}, {31'b0, AccessError}, 32'd0);
    cyc = 0; stalls = 0; wcnt = 0; seen_wr = 1'b0; obs_waddr = '0; obs_wdata = '0;
    while (!Done && cyc < 50) begin
      if (Stall) stalls++;
      @(negedge Clk);
      cyc++;
      // Later input changes must be ignored once the request is captured.
      MemRead = 1'b0; MemWrite = 1'b0; MemDataType = 2'b11;
      Address = 32'hDEAD_BEEF; WriteData = $urandom;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wcnt < waits) wcnt++;
        else begin
          mem_ack = 1'b1; mem_rdata = word; wcnt = 0;
          if (mem_we) begin seen_wr = 1'b1; obs_waddr = mem_addr; obs_wdata = mem_wdata; end
        end
      end
      #1;
    end
    mem_ack = 1'b0;
    if (!Done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    got = sb_q.pop_front();
    chk({got.tag, "_latency"}, cyc, got.lat);
    chk({got.tag, "_stall_cycles"}, stalls, got.lat);
    chk({got.tag, "_stall_fin"}, {31'b0, Stall}, 32'd0);
    chk({got.tag, "_readdata"}, ReadData, got.rd);
    chk({got.tag, "_wrote"}, {31'b0, seen_wr}, {31'b0, got.wr});
    if (got.wr) begin
      chk({got.tag, "_waddr"}, {2'b0, obs_waddr}, {2'b0, got.waddr});
      chk({got.tag, "_wdata"}, obs_wdata, got.wdata);
    end
  endtask

  // Present an illegal request for two cycles; nothing may start and ReadData must hold.
  task automatic run_err(input string tag, input logic rd, input logic wr, input logic [1:0] dt,
                         input logic [31:0] addr);
    MemRead = rd; MemWrite = wr; MemDataType = dt; Address = addr; WriteData = 32'h5A5A_5A5A;
    #1;
    chk({tag, "_aerr"}, {31'b0, AccessError}, 32'd1);
    chk({tag, "_stall"}, {31'b0, Stall}, 32'd0);
    chk({tag, "_req"}, {31'b0, mem_req}, 32'd0);
    @(negedge Clk);
    chk({tag, "_req_next"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_done_next"}, {31'b0, Done}, 32'd0);
    chk({tag, "_rd_hold"}, ReadData, exp_rd);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_aerr", {31'b0, AccessError}, 32'd0);
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_addr", {2'b0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);

    @(negedge Clk); Rst = 1'b1;
    run_op("lw_wait2", 1'b1, 2'b10, 32'h10, 32'h0, 32'h8000_00FF, 2);
    chk("lw_wait2_value", ReadData, 32'h8000_00FF);
    @(negedge Clk); run_op("lb_13", 1'b1, 2'b00, 32'h13, 32'h0, 32'h80FF_1234, 0);
    chk("lb_13_value", ReadData, 32'hFFFF_FF80);
    @(negedge Clk); run_op("lh_12", 1'b1, 2'b01, 32'h12, 32'h0, 32'h80FF_1234, 0);
    chk("lh_12_value", ReadData, 32'hFFFF_80FF);
    @(negedge Clk); run_op("lb_11", 1'b1, 2'b00, 32'h11, 32'h0, 32'h80FF_1234, 0);
    @(negedge Clk); run_op("lh_10", 1'b1, 2'b01, 32'h10, 32'h0, 32'h80FF_9234, 1);
    @(negedge Clk); run_op("sb_21", 1'b0, 2'b00, 32'h21, 32'h0000_00AB, 32'h1122_3344, 0);
    chk("sb_21_value", sb_q.size(), 32'd0);
    @(negedge Clk); run_op("sh_22", 1'b0, 2'b01, 32'h22, 32'h0000_BEEF, 32'h1122_3344, 0);
    @(negedge Clk); run_op("sw_44", 1'b0, 2'b10, 32'h44, 32'hCAFE_F00D, 32'h0, 1);
    @(negedge Clk); run_op("sb_12_wait", 1'b0, 2'b00, 32'h12, 32'h0000_0077, 32'hA5A5_A5A5, 1);

    @(negedge Clk); run_err("lh_13", 1'b1, 1'b0, 2'b01, 32'h13);
    @(negedge Clk); run_err("rd_wr", 1'b1, 1'b1, 2'b10, 32'h20);
    @(negedge Clk); run_err("dt_11", 1'b1, 1'b0, 2'b11, 32'h20);
    @(negedge Clk); run_err("sw_mis", 1'b0, 1'b1, 2'b10, 32'h42);

    // Abandon a sub-word store while the write phase waits for ack.
    @(negedge Clk);
    MemRead = 1'b0; MemWrite = 1'b1; MemDataType = 2'b00; Address = 32'h21;
    WriteData = 32'hAB; mem_ack = 1'b0;
    @(negedge Clk);
    MemWrite = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge Clk);
    mem_ack = 1'b0;
    chk("rmw_wr_we", {31'b0, mem_we}, 32'd1);
    chk("rmw_wr_wdata", mem_wdata, 32'h1122_AB44);
    #2 Rst = 1'b0;
    #1;
    chk("midrst_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_stall", {31'b0, Stall}, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_readdata", ReadData, 32'd0);
    exp_rd = '0;
    @(negedge Clk);
    chk("midrst_done", {31'b0, Done}, 32'd0);
    Rst = 1'b1;
    run_op("sw_40_after_rst", 1'b0, 2'b10, 32'h40, 32'h1234_5678, 32'h0, 0);

    @(negedge Clk);
    chk("idle_end_req", {31'b0, mem_req}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clk  input  1  sole clock, rising-edge.
REQ-002 Rst  input  1  reset, asynchronous, active-low.
REQ-003 MemRead  input  1  load request from decode.
REQ-004 MemWrite  input  1  store request from decode.
REQ-005 MemDataType  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-006 Address  input  32  byte address from the ALU.
REQ-007 WriteData  input  32  store data, right-justified.
REQ-008 ReadData  output  32  sign-extended load result, registered.
REQ-009 Stall  output  1  holds the pipeline while an access is in flight.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 AccessError  output  1  illegal or misaligned request flag.
REQ-012 mem_req  output  1  word-memory request, held until acknowledged.
REQ-013 mem_we  output  1  word-memory write enable, qualified by mem_req.
REQ-014 mem_addr  output  30  word address, equal to captured Address[31:2].
REQ-015 mem_wdata  output  32  word write data.
REQ-016 mem_rdata  input  32  word read data, valid with mem_ack.
REQ-017 mem_ack  input  1  memory acknowledge; sampled only while mem_req=1.

Function
REQ-018 The FSM SHALL have the states IDLE, RD, WR, RMW_RD, RMW_WR and FIN.
REQ-019 In IDLE, a legal request SHALL be accepted on the next edge, with Address, WriteData, MemDataType and the operation captured; input changes after that edge are ignored.
  - Load goes to RD.
  - Word store goes to WR.
  - Byte or half store goes to RMW_RD.
REQ-020 These requests SHALL be illegal:
  - MemRead and MemWrite both high.
  - MemDataType = 11.
  - Half access with Address[0] = 1.
  - Word access with Address[1:0] != 00.
REQ-021 An illegal request SHALL cause the following, combinationally in IDLE:
  - AccessError = 1.
  - Stall = 0.
  - No mem_req.
  - FSM stays in IDLE.
REQ-022 mem_req SHALL be 1 in RD, WR, RMW_RD and RMW_WR, and mem_we SHALL be 1 only in WR and RMW_WR.
  - mem_addr, mem_we and mem_wdata stay stable until mem_ack is seen.
  - mem_ack in the first mem_req cycle counts.
REQ-023 In RD, on mem_ack, the FSM SHALL load ReadData and go to FIN.
  - Lanes are little-endian.
  - Byte lane is Address[1:0], i.e. bits 8k+7:8k; the byte is sign-extended.
  - Half lane is Address[1], i.e. bits 16h+15:16h; the half is sign-extended.
  - Word is passed unchanged.
REQ-024 In RMW_RD, on mem_ack, the FSM SHALL register the merged word into mem_wdata and go to RMW_WR.
  - The selected lane is replaced with WriteData[7:0] or WriteData[15:0].
  - All other lanes come from mem_rdata.
REQ-025 In WR, mem_wdata SHALL equal the captured WriteData; in WR or RMW_WR, mem_ack SHALL move the FSM to FIN.
REQ-026 In FIN, the block SHALL assert Done=1 and Stall=0, then return to IDLE.
REQ-027 Stall SHALL be 1 in the IDLE cycle of a legal request and in RD, WR, RMW_RD and RMW_WR.
REQ-028 Latency with mem_ack asserted immediately SHALL be:
  - Load or word store: Done 2 cycles after accept.
  - Byte or half store: Done 3 cycles after accept.
  - Each wait cycle adds one cycle.
REQ-029 ReadData SHALL hold its value until the next load completes; stores and errors leave it unchanged.

Reset
REQ-030 While Rst=0, all of the following SHALL hold:
  - FSM in IDLE.
  - ReadData, mem_addr and mem_wdata = 0.
  - mem_req, mem_we, Done, Stall and AccessError = 0.
REQ-031 Reset asserted mid-access SHALL drop mem_req immediately and abandon the transaction, with no Done.
REQ-032 The first request SHALL be accepted on the first rising edge after Rst deasserts.

Structure
REQ-033 Package mem_pkg SHALL hold the following shared by controller and datapath:
  - DT_BYTE, DT_HALF and DT_WORD encodings.
  - FSM state encoding.
  - MEM_ADDR_W = 30.
REQ-034 Lane extraction, sign-extension and store merge SHALL live in the combinational sub-module lane_align.

Verification
REQ-035 lw 0x10, memory word 0x800000FF, 2 wait cycles -> Stall high 4 cycles, Done on the 5th, ReadData = 0x800000FF.
REQ-036 lb 0x13, memory word 0x80FF1234, zero-wait -> ReadData = 0xFFFFFF80; lh 0x12 on the same word -> 0xFFFF80FF.
REQ-037 sb 0x21, WriteData 0x000000AB, memory word 0x11223344, zero-wait -> read, then write mem_wdata = 0x1122AB44 at mem_addr 0x8, Done 3 cycles after accept.
REQ-038 lh 0x13, or MemRead and MemWrite both high -> AccessError = 1, Stall = 0, mem_req never asserted, ReadData unchanged.
REQ-039 Rst low in RMW_WR while mem_ack = 0 -> mem_req = 0 immediately, no Done; a subsequent sw 0x40 completes in 2 cycles.
